// File: rtl/cp0_pkg.sv
// CP0 shared constants: register numbers, exception codes,
// status/cause field positions and the handler entry point.
package cp0_pkg;

  typedef enum logic [4:0] {
    REG_COUNT   = 5'd9,
    REG_COMPARE = 5'd11,
    REG_SR      = 5'd12,
    REG_CAUSE   = 5'd13,
    REG_EPC     = 5'd14,
    REG_PRID    = 5'd15
  } cp0_reg_e;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int IM_MSB  = 15;
  localparam int IM_LSB  = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int IP_MSB  = 15;
  localparam int IP_LSB  = 10;
  localparam int EC_MSB  = 6;
  localparam int EC_LSB  = 2;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  // Victim PC: a delay-slot fault restarts at the branch.
  function automatic logic [31:0] epc_of(
    input logic [31:0] pc,
    input logic        bd
  );
    logic [31:0] a;
    a = bd ? pc - 32'd4 : pc;
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// M-stage <-> CP0 bundle: victim info, interrupts, mfc0/mtc0/eret
// inputs (master drives) and read data, EPC, req (slave drives).
interface cp0_exc_unit_if;
  logic [31:0] M_pc;
  logic [4:0]  ExcIn;
  logic        bd;
  logic [5:0]  HWInt;
  logic        we;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0In;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        req;

  modport master (
    output M_pc, ExcIn, bd, HWInt,
    output we, CP0Addr, CP0In, EXLClr,
    input  CP0Out, EPCOut, req
  );

  modport slave (
    input  M_pc, ExcIn, bd, HWInt,
    input  we, CP0Addr, CP0In, EXLClr,
    output CP0Out, EPCOut, req
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer. Ports: clk, reset (async low), count_we_i,
// cmp_we_i, wdata_i -> count_o, compare_o, pend_o.
module cp0_timer #(
  parameter int unsigned COUNT_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we_i,
  input  logic        cmp_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pend_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        pend_q, pend_d;
  logic        hit;

  // Count==0 is excluded so the reset state never fires.
  assign hit = (count_q == cmp_q) && (count_q != 32'd0);

  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    pend_d  = pend_q | hit;
    if (COUNT_EN != 0) count_d = count_q + 32'd1;
    if (count_we_i) count_d = wdata_i;
    if (cmp_we_i) begin
      cmp_d  = wdata_i;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      cmp_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = cmp_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 + exception arbitration for M stage. Ports: clk, reset
// (async low), bus (slave): victim/irq/mfc0/mtc0 in, req/reads out.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h0000_5A01,
  parameter int unsigned COUNT_EN = 1
) (
  input logic           clk,
  input logic           reset,
  cp0_exc_unit_if.slave bus
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  ec_q, ec_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] count, compare;
  logic        pend;
  logic [5:0]  ip_eff;
  logic        int_req, exc_req, req, wr;
  logic        sel_count, sel_cmp, sel_sr;
  logic        sel_cause, sel_epc, sel_prid;
  logic [31:0] sr_rd, cause_rd, rd;

  assign ip_eff  = {bus.HWInt[5] | pend, bus.HWInt[4:0]};
  assign int_req = ie_q & ~exl_q & (|(ip_eff & im_q));
  assign exc_req = (bus.ExcIn != 5'd0) & ~exl_q;
  // Held low while in reset so no flush leaks out.
  assign req     = reset & (int_req | exc_req);
  assign wr      = bus.we & ~req;

  assign sel_count = bus.CP0Addr == REG_COUNT;
  assign sel_cmp   = bus.CP0Addr == REG_COMPARE;
  assign sel_sr    = bus.CP0Addr == REG_SR;
  assign sel_cause = bus.CP0Addr == REG_CAUSE;
  assign sel_epc   = bus.CP0Addr == REG_EPC;
  assign sel_prid  = bus.CP0Addr == REG_PRID;

  cp0_timer #(
    .COUNT_EN (COUNT_EN)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we_i (wr & sel_count),
    .cmp_we_i   (wr & sel_cmp),
    .wdata_i    (bus.CP0In),
    .count_o    (count),
    .compare_o  (compare),
    .pend_o     (pend)
  );

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = ip_eff;
    ec_d  = ec_q;
    epc_d = epc_q;
    if (req) begin
      exl_d = 1'b1;
      bd_d  = bus.bd;
      ec_d  = int_req ? EXC_INT : bus.ExcIn;
      epc_d = epc_of(bus.M_pc, bus.bd);
    end else begin
      if (wr && sel_sr) begin
        im_d  = bus.CP0In[IM_MSB:IM_LSB];
        exl_d = bus.CP0In[EXL_BIT];
        ie_d  = bus.CP0In[IE_BIT];
      end
      if (wr && sel_epc) epc_d = bus.CP0In;
      if (bus.EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      ec_q  <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      ec_q  <= ec_d;
      epc_q <= epc_d;
    end
  end

  assign sr_rd    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_rd = {bd_q, 15'b0, ip_q, 3'b0, ec_q, 2'b0};

  always_comb begin
    rd = '0;
    unique case (1'b1)
      sel_count: rd = count;
      sel_cmp:   rd = compare;
      sel_sr:    rd = sr_rd;
      sel_cause: rd = cause_rd;
      sel_epc:   rd = epc_q;
      sel_prid:  rd = PRID;
      default:   rd = '0;
    endcase
  end

  assign bus.CP0Out = rd;
  assign bus.EPCOut = (wr && sel_epc) ? bus.CP0In : epc_q;
  assign bus.req    = req;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed vector table, async reset
// sequence, then random traffic against a word-level CP0 model.
module tb_cp0_exc_unit;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  cp0_exc_unit_if bus ();

  cp0_exc_unit #(
    .PRID     (32'h0000_5A01),
    .COUNT_EN (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] pc;
    logic [5:0]  hw;
    logic        clr;
    logic        e_req;
    logic [31:0] e_out;
    logic [31:0] e_epc;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl [NV];

  // model state, whole 32-bit register images
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_cmp;
  logic        m_pend;
  logic [31:0] n_sr, n_cause, n_epc, n_count, n_cmp;
  logic        n_pend;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] a,
                       input logic [31:0] d,
                       input logic [4:0] e, input logic b,
                       input logic [31:0] pc,
                       input logic [5:0] hw, input logic c);
    bus.we      = we;
    bus.CP0Addr = a;
    bus.CP0In   = d;
    bus.ExcIn   = e;
    bus.bd      = b;
    bus.M_pc    = pc;
    bus.HWInt   = hw;
    bus.EXLClr  = c;
  endtask

  task automatic model_reset();
    m_sr = 0; m_cause = 0; m_epc = 0;
    m_count = 0; m_cmp = 0; m_pend = 0;
  endtask

  task automatic model_out(output logic e_req,
                           output logic ireq,
                           output logic [31:0] e_out,
                           output logic [31:0] e_epc);
    logic [5:0] ipe;
    ipe = {bus.HWInt[5] | m_pend, bus.HWInt[4:0]};
    ireq = m_sr[0] && !m_sr[1] &&
           ((ipe & m_sr[15:10]) != 6'd0);
    e_req = ireq || (bus.ExcIn != 5'd0 && !m_sr[1]);
    case (int'(bus.CP0Addr))
      9:  e_out = m_count;
      11: e_out = m_cmp;
      12: e_out = m_sr;
      13: e_out = m_cause;
      14: e_out = m_epc;
      15: e_out = 32'h0000_5A01;
      default: e_out = 0;
    endcase
    e_epc = (bus.we && bus.CP0Addr == 5'd14 && !e_req)
          ? bus.CP0In : m_epc;
  endtask

  task automatic model_next(input logic e_req,
                            input logic ireq);
    logic [31:0] v;
    n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
    n_cmp = m_cmp;
    n_count = m_count + 1;
    n_pend = m_pend ||
             (m_count == m_cmp && m_count != 0);
    n_cause[15:10] = {bus.HWInt[5] | m_pend,
                      bus.HWInt[4:0]};
    if (e_req) begin
      n_sr[1] = 1'b1;
      n_cause[31] = bus.bd;
      n_cause[6:2] = ireq ? 5'd0 : bus.ExcIn;
      v = bus.bd ? bus.M_pc - 4 : bus.M_pc;
      n_epc = v & ~32'h3;
    end else begin
      if (bus.we) begin
        case (int'(bus.CP0Addr))
          9:  n_count = bus.CP0In;
          11: begin n_cmp = bus.CP0In; n_pend = 0; end
          12: n_sr = bus.CP0In & 32'h0000_FC03;
          14: n_epc = bus.CP0In;
          default: ;
        endcase
      end
      if (bus.EXLClr) n_sr[1] = 1'b0;
    end
  endtask

  task automatic model_commit();
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    m_count = n_count; m_cmp = n_cmp; m_pend = n_pend;
  endtask

  task automatic rand_drive();
    logic [4:0]  e, a;
    logic [31:0] d;
    logic [4:0]  codes [4];
    codes[0] = 5'd4;  codes[1] = 5'd5;
    codes[2] = 5'd10; codes[3] = 5'd12;
    e = 0;
    if ($urandom_range(0, 9) == 0)
      e = $urandom_range(0, 1) ? codes[$urandom_range(0, 3)]
                               : 5'($urandom_range(1, 31));
    case ($urandom_range(0, 6))
      0: a = 5'd9;
      1: a = 5'd11;
      2: a = 5'd12;
      3: a = 5'd13;
      4: a = 5'd14;
      5: a = 5'd15;
      default: a = 5'($urandom);
    endcase
    d = $urandom;
    if (a == 5'd11) d = m_count + $urandom_range(1, 6);
    drive($urandom_range(0, 3) == 0, a, d, e,
          1'($urandom), $urandom,
          ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0,
          $urandom_range(0, 5) == 0);
  endtask

  initial begin
    logic        e_req, ireq;
    logic [31:0] e_out, e_epc;
    clk = 0;
    reset = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //          we adr din          exc bd pc       hw clr req out  epc
    tbl[0]  = '{0, 12, 0,            0, 0, 0,       0, 0, 0, 0, 0};
    tbl[1]  = '{0, 13, 0,            0, 0, 0,       0, 0, 0, 0, 0};
    tbl[2]  = '{0, 14, 0,            0, 0, 0,       0, 0, 0, 0, 0};
    tbl[3]  = '{0, 9,  0,            0, 0, 0,       0, 0, 0, 3, 0};
    tbl[4]  = '{0, 15, 0,            0, 0, 0,       0, 0, 0,
                32'h5A01, 0};
    tbl[5]  = '{0, 12, 0,           12, 0, 'h3010,  0, 0, 1, 0, 0};
    tbl[6]  = '{0, 14, 0,            4, 0, 0,       0, 0, 0,
                'h3010, 'h3010};
    tbl[7]  = '{0, 13, 0,            0, 0, 0,       0, 0, 0,
                'h30, 'h3010};
    tbl[8]  = '{0, 12, 0,            0, 0, 0,       0, 0, 0, 2, 'h3010};
    tbl[9]  = '{0, 12, 0,            0, 0, 0,       0, 1, 0, 2, 'h3010};
    tbl[10] = '{0, 12, 0,            0, 0, 0,       0, 0, 0, 0, 'h3010};
    tbl[11] = '{0, 14, 0,           10, 1, 'h3024,  0, 0, 1,
                'h3010, 'h3010};
    tbl[12] = '{0, 14, 0,            0, 0, 0,       0, 0, 0,
                'h3020, 'h3020};
    tbl[13] = '{0, 13, 0,            0, 0, 0,       0, 0, 0,
                32'h8000_0028, 'h3020};
    tbl[14] = '{0, 12, 0,            0, 0, 0,       0, 1, 0, 2, 'h3020};
    tbl[15] = '{1, 12, 'h401,        0, 0, 0,       0, 0, 0, 0, 'h3020};
    tbl[16] = '{1, 14, 32'hDEAD_BEE0, 4, 0, 'h3100, 1, 0, 1,
                'h3020, 'h3020};
    tbl[17] = '{0, 13, 0,            0, 0, 0,       0, 0, 0,
                'h400, 'h3100};
    tbl[18] = '{0, 14, 0,            0, 0, 0,       0, 0, 0,
                'h3100, 'h3100};
    tbl[19] = '{0, 12, 0,            0, 0, 0,       0, 0, 0,
                'h403, 'h3100};
    tbl[20] = '{1, 12, 'h8003,       0, 0, 0,       0, 1, 0,
                'h403, 'h3100};
    tbl[21] = '{0, 12, 0,            0, 0, 0,       0, 0, 0,
                'h8001, 'h3100};
    tbl[22] = '{1, 11, 25,           0, 0, 0,       0, 0, 0, 0, 'h3100};
    tbl[23] = '{0, 11, 0,            0, 0, 0,       0, 0, 0, 25, 'h3100};
    tbl[24] = '{0, 13, 0,            0, 0, 0,       0, 0, 0, 0, 'h3100};
    tbl[25] = '{0, 9,  0,            0, 0, 0,       0, 0, 0, 25, 'h3100};
    tbl[26] = '{0, 13, 0,            0, 0, 'h3200,  0, 0, 1, 0, 'h3100};
    tbl[27] = '{0, 13, 0,            0, 0, 0,       0, 0, 0,
                'h8000, 'h3200};
    tbl[28] = '{1, 11, 100,          0, 0, 0,       0, 0, 0, 25, 'h3200};
    tbl[29] = '{0, 13, 0,            0, 0, 0,       0, 1, 0,
                'h8000, 'h3200};
    tbl[30] = '{0, 13, 0,            0, 0, 0,       0, 0, 0, 0, 'h3200};
    tbl[31] = '{1, 14, 'h3400,       0, 0, 0,       0, 0, 0,
                'h3200, 'h3400};
    tbl[32] = '{0, 14, 0,            0, 0, 0,       0, 0, 0,
                'h3400, 'h3400};

    repeat (3) @(posedge clk);
    #1 reset = 1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].exc,
            tbl[i].bd, tbl[i].pc, tbl[i].hw, tbl[i].clr);
      @(negedge clk);
      chk("tbl_req", i, 32'(bus.req), 32'(tbl[i].e_req));
      chk("tbl_out", i, bus.CP0Out, tbl[i].e_out);
      chk("tbl_epc", i, bus.EPCOut, tbl[i].e_epc);
      @(posedge clk);
      #1;
    end

    // async reset while an exception is being requested
    drive(0, 14, 0, 5, 0, 'h3500, 0, 0);
    #2 chk("rst_pre_req", 0, 32'(bus.req), 1);
    reset = 0;
    #1 chk("rst_req", 0, 32'(bus.req), 0);
    chk("rst_epc_rd", 0, bus.CP0Out, 0);
    chk("rst_epcout", 0, bus.EPCOut, 0);
    bus.CP0Addr = 12;
    #1 chk("rst_sr", 0, bus.CP0Out, 0);
    bus.CP0Addr = 9;
    #1 chk("rst_count", 0, bus.CP0Out, 0);
    bus.CP0Addr = 11;
    #1 chk("rst_cmp", 0, bus.CP0Out, 0);
    bus.CP0Addr = 13;
    #1 chk("rst_cause", 0, bus.CP0Out, 0);

    repeat (2) @(posedge clk);
    #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    reset = 1;

    for (int c = 0; c < 1500; c++) begin
      rand_drive();
      @(negedge clk);
      model_out(e_req, ireq, e_out, e_epc);
      chk("rnd_req", c, 32'(bus.req), 32'(e_req));
      chk("rnd_out", c, bus.CP0Out, e_out);
      chk("rnd_epc", c, bus.EPCOut, e_epc);
      model_next(e_req, ireq);
      @(posedge clk);
      #1 model_commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
